// File: rtl/kernel_window_fetch_multi.sv
// Multi-channel KxK neighbourhood fetch from a pixel ROM with edge clamping.
// Define KWF_ZERO_PAD_EN to zero the taps that fall outside the image instead.
module kernel_window_fetch_multi #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int K      = 3,
    parameter int CH     = 2,
    parameter int DATA_W = 13,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CH*13-1:0]           idx,
    output logic [CH*ADDR_W-1:0]       addr,
    input  logic [CH*DATA_W-1:0]       data,
    output logic [CH*K*K*DATA_W-1:0]   win,
    output logic                       busy,
    output logic                       done,
    output logic [CH-1:0]              err
);
    localparam int TAPS = K * K;
    localparam int TW   = $clog2(TAPS + 1);
    localparam int HALF = (K - 1) / 2;
    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [12:0] W13 = 13'(IMG_W);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_reg;
    logic [TW-1:0]       tap_reg;
    logic [1:0]          drain_reg;
    logic [CH*13-1:0]    idx_reg;
    logic                addr_vld_reg;
    logic [RD_LAT-1:0]   pvld_reg;
    logic [TW-1:0]       ptap_reg [RD_LAT];
    logic [DATA_W-1:0]   shadow_reg  [CH][TAPS];
    logic [DATA_W-1:0]   shadow_next [CH][TAPS];
    logic [CH*ADDR_W-1:0]      addr_next;
    logic [CH*TAPS*DATA_W-1:0] win_next;
    logic [CH-1:0]       err_next;
    logic [CH*13-1:0]    idx_sel;
    logic [TW-1:0]       tap_sel;

    // The accepting edge already drives tap 0, so it must use the live idx.
    assign idx_sel = (state_reg == IDLE) ? idx : idx_reg;
    assign tap_sel = (state_reg == IDLE) ? '0 : tap_reg + TW'(1);

    genvar gi, gj;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [12:0]        row_u, col_u;
            logic signed [15:0] row_s, col_s;
            logic [15:0]        row_cl, col_cl;

            assign row_u = idx_sel[gi*13 +: 13] / W13;
            assign col_u = idx_sel[gi*13 +: 13] % W13;
            assign row_s = 16'(row_u) + 16'(tap_sel / TW'(K)) - 16'(HALF);
            assign col_s = 16'(col_u) + 16'(tap_sel % TW'(K)) - 16'(HALF);
            assign row_cl = (row_s < 0) ? 16'd0 :
                            (row_s > $signed(16'(IMG_H - 1))) ? 16'(IMG_H - 1) : row_s;
            assign col_cl = (col_s < 0) ? 16'd0 :
                            (col_s > $signed(16'(IMG_W - 1))) ? 16'(IMG_W - 1) : col_s;
            assign addr_next[gi*ADDR_W +: ADDR_W] =
                ADDR_W'(32'(row_cl) * 32'(IMG_W) + 32'(col_cl));
            assign err_next[gi] = 32'(idx_reg[gi*13 +: 13]) >= 32'(NPIX);

            for (gj = 0; gj < TAPS; gj++) begin : g_tap
                logic zero_tap;
`ifdef KWF_ZERO_PAD_EN
                localparam int DR = gj / K - HALF;
                localparam int DC = gj % K - HALF;
                logic signed [15:0] pr, pc;
                assign pr = 16'(idx_reg[gi*13 +: 13] / W13) + 16'(DR);
                assign pc = 16'(idx_reg[gi*13 +: 13] % W13) + 16'(DC);
                assign zero_tap = err_next[gi] || (pr < 0) || (pc < 0) ||
                                  (pr > $signed(16'(IMG_H - 1))) ||
                                  (pc > $signed(16'(IMG_W - 1)));
`else
                assign zero_tap = err_next[gi];
`endif
                // Last tap lands on the same edge that raises done, so merge it in.
                assign shadow_next[gi][gj] =
                    (pvld_reg[RD_LAT-1] && ptap_reg[RD_LAT-1] == TW'(gj)) ?
                    data[gi*DATA_W +: DATA_W] : shadow_reg[gi][gj];
                assign win_next[(gi*TAPS+gj)*DATA_W +: DATA_W] =
                    zero_tap ? '0 : shadow_next[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            tap_reg      <= '0;
            drain_reg    <= '0;
            idx_reg      <= '0;
            addr_vld_reg <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= '0;
            addr         <= '0;
            win          <= '0;
        end else begin
            addr_vld_reg <= 1'b0;
            done         <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    idx_reg      <= idx;
                    addr         <= addr_next;
                    addr_vld_reg <= 1'b1;
                    tap_reg      <= '0;
                    busy         <= 1'b1;
                    state_reg    <= ISSUE;
                end
                ISSUE: if (tap_reg == TW'(TAPS - 1)) begin
                    drain_reg <= '0;
                    state_reg <= DRAIN;
                end else begin
                    tap_reg      <= tap_reg + TW'(1);
                    addr         <= addr_next;
                    addr_vld_reg <= 1'b1;
                end
                DRAIN: if (drain_reg == 2'(RD_LAT - 1)) begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    err       <= err_next;
                    win       <= win_next;
                    state_reg <= DONE;
                end else begin
                    drain_reg <= drain_reg + 2'd1;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tap tags ride alongside the ROM latency so each return finds its slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pvld_reg[i] <= 1'b0;
                ptap_reg[i] <= '0;
            end
            for (int c = 0; c < CH; c++)
                for (int t = 0; t < TAPS; t++)
                    shadow_reg[c][t] <= '0;
        end else begin
            pvld_reg[0] <= addr_vld_reg;
            ptap_reg[0] <= tap_reg;
            for (int i = 1; i < RD_LAT; i++) begin
                pvld_reg[i] <= pvld_reg[i-1];
                ptap_reg[i] <= ptap_reg[i-1];
            end
            for (int c = 0; c < CH; c++)
                for (int t = 0; t < TAPS; t++)
                    shadow_reg[c][t] <= shadow_next[c][t];
        end
    end
endmodule

// File: tb/tb_kernel_window_fetch_multi.sv
// Bench for kernel_window_fetch_multi: default build plus a K=5, RD_LAT=3 single-channel instance.
module tb_kernel_window_fetch_multi;
    localparam int W = 64, H = 64, CH = 2, DW = 13, AW = 12;
    localparam int K1 = 3, L1 = 1, T1 = K1 * K1;
    localparam int K2 = 5, L2 = 3, T2 = K2 * K2;

    logic clk = 1'b0;
    logic rst, rst2, start, start2;
    logic [CH*13-1:0]     idx;
    logic [12:0]          idx2;
    logic [CH*AW-1:0]     addr1;
    logic [CH*DW-1:0]     data1;
    logic [CH*T1*DW-1:0]  win1;
    logic                 busy1, done1;
    logic [CH-1:0]        err1;
    logic [AW-1:0]        addr2;
    logic [DW-1:0]        data2;
    logic [T2*DW-1:0]     win2;
    logic                 busy2, done2;
    logic                 err2;

    logic [CH*AW-1:0] rom1 [L1];
    logic [AW-1:0]    rom2 [L2];

    logic [CH*T1*DW-1:0] exp_win1_q[$];
    logic [CH-1:0]       exp_err1_q[$];
    logic [T2*DW-1:0]    exp_win2_q[$];

    int cmp_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    kernel_window_fetch_multi #(.IMG_W(W), .IMG_H(H), .K(K1), .CH(CH), .DATA_W(DW),
                                .ADDR_W(AW), .RD_LAT(L1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .idx(idx), .addr(addr1), .data(data1),
        .win(win1), .busy(busy1), .done(done1), .err(err1));

    kernel_window_fetch_multi #(.IMG_W(W), .IMG_H(H), .K(K2), .CH(1), .DATA_W(DW),
                                .ADDR_W(AW), .RD_LAT(L2)) u_dut2 (
        .clk(clk), .rst(rst2), .start(start2), .idx(idx2), .addr(addr2), .data(data2),
        .win(win2), .busy(busy2), .done(done2), .err(err2));

    // ROM returns its own address, RD_LAT cycles late.
    always @(posedge clk) begin
        rom1[0] <= addr1;
        rom2[0] <= addr2;
        for (int i = 1; i < L2; i++) rom2[i] <= rom2[i-1];
    end
    assign data1 = {1'b0, rom1[L1-1][2*AW-1:AW], 1'b0, rom1[L1-1][AW-1:0]};
    assign data2 = {1'b0, rom2[L2-1]};

    function automatic int model_tap(int kk, int iv, int t);
        int r, q, h, rr, cc;
        r = iv / W; q = iv % W; h = (kk - 1) / 2;
        rr = r + t / kk - h; cc = q + t % kk - h;
`ifdef KWF_ZERO_PAD_EN
        if (rr < 0 || rr > H - 1 || cc < 0 || cc > W - 1) return 0;
`endif
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        return (rr * W + cc) % (1 << AW);
    endfunction

    function automatic logic [CH*T1*DW-1:0] model_win1(int i0, int i1);
        logic [CH*T1*DW-1:0] w;
        int iv;
        w = '0;
        for (int c = 0; c < CH; c++) begin
            iv = (c == 0) ? i0 : i1;
            for (int t = 0; t < T1; t++)
                w[(c*T1+t)*DW +: DW] = (iv >= W * H) ? '0 : DW'(model_tap(K1, iv, t));
        end
        return w;
    endfunction

    function automatic logic [T2*DW-1:0] model_win2(int iv);
        logic [T2*DW-1:0] w;
        for (int t = 0; t < T2; t++) w[t*DW +: DW] = DW'(model_tap(K2, iv, t));
        return w;
    endfunction

    // Drives one accepted fetch on the default instance and waits for done.
    task automatic run1(input logic [12:0] i0, input logic [12:0] i1,
                        input logic [CH*T1*DW-1:0] exp_w, output int lat);
        @(negedge clk);
        idx = {i1, i0};
        start = 1'b1;
        exp_win1_q.push_back(exp_w);
        exp_err1_q.push_back({i1 >= 13'(W * H), i0 >= 13'(W * H)});
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; rst2 = 1'b1; start = 1'b1; start2 = 1'b1; idx = '0; idx2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst2 = 1'b0; start = 1'b0; start2 = 1'b0;
        @(negedge clk);
        cmp_count++; if (busy1 !== 1'b0) begin err_count++; $display("FAIL reset_busy got %b exp 0", busy1); end
        cmp_count++; if (done1 !== 1'b0) begin err_count++; $display("FAIL reset_done got %b exp 0", done1); end
        cmp_count++; if (err1 !== 2'b00) begin err_count++; $display("FAIL reset_err got %b exp 00", err1); end
        cmp_count++; if (addr1 !== '0) begin err_count++; $display("FAIL reset_addr got %h exp 0", addr1); end
        cmp_count++; if (win1 !== '0) begin err_count++; $display("FAIL reset_win got %h exp 0", win1); end
        cmp_count++; if (busy2 !== 1'b0) begin err_count++; $display("FAIL reset_busy2 got %b exp 0", busy2); end
        cmp_count++; if (win2 !== '0) begin err_count++; $display("FAIL reset_win2 got %h exp 0", win2); end
        $display("reset: busy=%b done=%b err=%b", busy1, done1, err1);
    endtask

    task automatic test_clamp_corner();
        int ref0 [T1];
        logic [CH*T1*DW-1:0] e;
        int lat;
`ifdef KWF_ZERO_PAD_EN
        ref0 = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
`else
        ref0 = '{0, 0, 1, 0, 0, 1, 64, 64, 65};
`endif
        e = model_win1(0, 200);
        for (int t = 0; t < T1; t++) e[t*DW +: DW] = DW'(ref0[t]);
        run1(13'd0, 13'd200, e, lat);
        cmp_count++; if (lat != T1 + L1 + 1) begin err_count++; $display("FAIL corner_latency got %0d exp %0d", lat, T1 + L1 + 1); end
        if (lat > 0) begin
            cmp_count++; if (win1 !== exp_win1_q[0]) begin err_count++; $display("FAIL corner_win got %h exp %h", win1, exp_win1_q[0]); end
            cmp_count++; if (err1 !== exp_err1_q[0]) begin err_count++; $display("FAIL corner_err got %b exp %b", err1, exp_err1_q[0]); end
        end
        void'(exp_win1_q.pop_front()); void'(exp_err1_q.pop_front());
        $display("corner idx0=0: latency=%0d win=%h", lat, win1);
    endtask

    task automatic test_multi_channel();
        int ref0 [T1] = '{65, 66, 67, 129, 130, 131, 193, 194, 195};
        int ref1 [T1] = '{4030, 4031, 4031, 4094, 4095, 4095, 4094, 4095, 4095};
        logic [CH*T1*DW-1:0] e;
        int lat;
        for (int t = 0; t < T1; t++) begin
            e[t*DW +: DW]      = DW'(ref0[t]);
            e[(T1+t)*DW +: DW] = DW'(ref1[t]);
        end
`ifdef KWF_ZERO_PAD_EN
        e = model_win1(130, 4095);
`endif
        run1(13'd130, 13'd4095, e, lat);
        cmp_count++; if (win1 !== exp_win1_q[0]) begin err_count++; $display("FAIL multi_win got %h exp %h", win1, exp_win1_q[0]); end
        cmp_count++; if (err1 !== exp_err1_q[0]) begin err_count++; $display("FAIL multi_err got %b exp %b", err1, exp_err1_q[0]); end
        void'(exp_win1_q.pop_front()); void'(exp_err1_q.pop_front());
        repeat (3) @(negedge clk);
        cmp_count++; if (addr1 !== {12'd4095, 12'd195}) begin err_count++; $display("FAIL multi_addr_hold got %h exp %h", addr1, {12'd4095, 12'd195}); end
        cmp_count++; if (done1 !== 1'b0) begin err_count++; $display("FAIL multi_done_pulse got %b exp 0", done1); end
        $display("multi idx=130/4095: latency=%0d addr=%h", lat, addr1);
    endtask

    task automatic test_err_channel();
        int lat;
        run1(13'd77, 13'd4096, model_win1(77, 4096), lat);
        cmp_count++; if (err1 !== 2'b10) begin err_count++; $display("FAIL err_flag got %b exp 10", err1); end
        cmp_count++; if (win1 !== exp_win1_q[0]) begin err_count++; $display("FAIL err_win got %h exp %h", win1, exp_win1_q[0]); end
        void'(exp_win1_q.pop_front()); void'(exp_err1_q.pop_front());
        $display("err idx1=4096: err=%b win=%h", err1, win1);
    endtask

    task automatic test_back_to_back();
        int nd = 0, d1 = 0, d2 = 0;
        @(negedge clk);
        idx = {13'd1000, 13'd2100};
        start = 1'b1;
        exp_win1_q.push_back(model_win1(2100, 1000));
        exp_err1_q.push_back(2'b00);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                idx = {13'd63, 13'd4032};
                exp_win1_q.push_back(model_win1(4032, 63));
                exp_err1_q.push_back(2'b00);
            end
            if (done1) begin
                nd++;
                cmp_count++; if (win1 !== exp_win1_q[0]) begin err_count++; $display("FAIL b2b_win%0d got %h exp %h", nd, win1, exp_win1_q[0]); end
                cmp_count++; if (err1 !== exp_err1_q[0]) begin err_count++; $display("FAIL b2b_err%0d got %b exp %b", nd, err1, exp_err1_q[0]); end
                void'(exp_win1_q.pop_front()); void'(exp_err1_q.pop_front());
                if (nd == 1) d1 = n;
                else begin d2 = n; break; end
            end
        end
        start = 1'b0;
        cmp_count++; if (nd != 2) begin err_count++; $display("FAIL b2b_count got %0d exp 2", nd); end
        cmp_count++; if (d2 - d1 != T1 + L1 + 2) begin err_count++; $display("FAIL b2b_gap got %0d exp %0d", d2 - d1, T1 + L1 + 2); end
        exp_win1_q.delete(); exp_err1_q.delete();
        $display("back_to_back: done at %0d and %0d", d1, d2);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_k5_latency_ignore();
        int lat = -1, extra = 0;
        @(negedge clk);
        idx2 = 13'd2080; start2 = 1'b1;
        exp_win2_q.push_back(model_win2(2080));
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            start2 = (n == 5);
            if (n == 5) idx2 = 13'd0;
            if (n == 3) begin
                cmp_count++; if (busy2 !== 1'b1) begin err_count++; $display("FAIL k5_busy got %b exp 1", busy2); end
            end
            if (done2) begin lat = n; break; end
        end
        start2 = 1'b0;
        cmp_count++; if (lat != T2 + L2 + 1) begin err_count++; $display("FAIL k5_latency got %0d exp %0d", lat, T2 + L2 + 1); end
        cmp_count++; if (win2 !== exp_win2_q[0]) begin err_count++; $display("FAIL k5_win got %h exp %h", win2, exp_win2_q[0]); end
        void'(exp_win2_q.pop_front());
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done2 || busy2) extra++;
        end
        cmp_count++; if (extra != 0) begin err_count++; $display("FAIL k5_ignored_start got %0d active cycles exp 0", extra); end
        $display("k5 idx=2080: latency=%0d extra=%0d", lat, extra);
    endtask

    task automatic test_k5_reset_abort();
        int seen = 0, lat = -1;
        @(negedge clk);
        idx2 = 13'd5; start2 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            start2 = 1'b0;
            if (n == 10) rst2 = 1'b1;
        end
        @(negedge clk);
        rst2 = 1'b0;
        cmp_count++; if (busy2 !== 1'b0) begin err_count++; $display("FAIL abort_busy got %b exp 0", busy2); end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done2) seen++;
        end
        cmp_count++; if (seen != 0) begin err_count++; $display("FAIL abort_done got %0d exp 0", seen); end
        cmp_count++; if (win2 !== '0) begin err_count++; $display("FAIL abort_win got %h exp 0", win2); end
        // The instance must recover cleanly after the abort.
        @(negedge clk);
        idx2 = 13'd4095; start2 = 1'b1;
        exp_win2_q.push_back(model_win2(4095));
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            start2 = 1'b0;
            if (done2) begin lat = n; break; end
        end
        cmp_count++; if (lat != T2 + L2 + 1) begin err_count++; $display("FAIL recover_latency got %0d exp %0d", lat, T2 + L2 + 1); end
        cmp_count++; if (win2 !== exp_win2_q[0]) begin err_count++; $display("FAIL recover_win got %h exp %h", win2, exp_win2_q[0]); end
        void'(exp_win2_q.pop_front());
        $display("k5 reset abort: done_seen=%0d recover_latency=%0d", seen, lat);
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0; idx = '0; idx2 = '0;
        test_reset();
        test_clamp_corner();
        test_multi_channel();
        test_err_channel();
        test_back_to_back();
        test_k5_latency_ignore();
        test_k5_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
